id_ex_hazard_reg: RTL and testbench
===================================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core, directly downstream of the control unit.
//  Latches the control unit's WB/M/EX buses together with the ID-stage operands.
//  Detects load-use hazards against the instruction already held in EX.
//  On a hazard or a branch flush it inserts a bubble and stalls upstream; it also keeps saturating bubble/flush counters for the debug unit.
// PARAMETERS
//  NB_DATA     32  operand / PC / immediate width
//  NB_ADDR     5   register index width
//  NB_CTRL_EX  7   EX control bus width (opaque, passed through)
//  NB_CTRL_M   3   M control bus: [2]=MemRead [1]=MemWrite [0]=Branch
//  NB_CTRL_WB  2   WB control bus: [1]=RegWrite [0]=MemtoReg
//  NB_CNT      16  width of each statistics counter
// PORTS
//  i_clk           in   1           clock, rising edge
//  i_rst           in   1           synchronous reset, active-high
//  i_enable        in   1           debug step enable; 0 freezes every register
//  i_flush         in   1           branch/jump taken; discard the ID instruction
//  i_ctrl_wb_bus   in   NB_CTRL_WB  from control unit
//  i_ctrl_mem_bus  in   NB_CTRL_M   from control unit
//  i_ctrl_exc_bus  in   NB_CTRL_EX  from control unit
//  i_pc_next       in   NB_DATA     PC+4 of the ID instruction
//  i_rs_data       in   NB_DATA     register file port A
//  i_rt_data       in   NB_DATA     register file port B
//  i_imm_ext       in   NB_DATA     sign-extended immediate
//  i_rs, i_rt, i_rd in  NB_ADDR     register indices of the ID instruction
//  o_ctrl_*_bus    out  as inputs   registered control buses to EX
//  o_pc_next, o_rs_data, o_rt_data, o_imm_ext  out  NB_DATA  registered data
//  o_rs, o_rt, o_rd out NB_ADDR     registered indices (o_rs/o_rt also feed forwarding)
//  o_stall         out  1           combinational; holds PC and IF/ID this cycle
//  o_bubble_cnt    out  NB_CNT      count of load-use bubbles inserted
//  o_flush_cnt     out  NB_CNT      count of flush bubbles inserted
// BEHAVIOUR
//  - Reset: all registered outputs are 0. This includes the counters and every control bus (EX holds a NOP).
//  - Hazard is combinational: o_ctrl_mem_bus[2] & (o_rt != 0) & (o_rt == i_rs | o_rt == i_rt).
//  - o_stall = hazard & ~i_flush. A flush suppresses the stall because the ID instruction is discarded anyway.
//  - Rising-edge update priority: i_rst > ~i_enable > i_flush > hazard > normal.
//    ~i_enable: all registers, counters included, hold their value.
//    i_flush: control buses <= 0; data/index fields capture the inputs; o_flush_cnt += 1.
//    hazard: control buses <= 0; data/index fields capture the inputs; o_bubble_cnt += 1.
//    normal: all fields capture their inputs. Latency is 1 cycle.
//  - A load-use stall lasts exactly 1 cycle. After the bubble, MemRead in EX is 0, so the hazard clears.
//  - Load followed by two consecutive dependants: the single bubble suffices for both; the second is covered by forwarding.
//  - Counters saturate at all-ones; no wrap-around.
//  - The bubble/flush FSM is implicit (RUN/BUBBLE per cycle); no other state exists.
//  - Reset mid-stall clears the EX load, so o_stall drops to 0 in the cycle after reset.
//  - o_stall is evaluated even when i_enable=0, so the debug unit sees the pending hazard.
// TESTING
//  1 Reset: i_rst=1 for 2 cycles with nonzero inputs -> all outputs 0, o_stall=0.
//  2 Pass-through: R-type ctrl wb=2'b10, ex=7'h41, rs_data=32'h5, rd=3 -> on next edge outputs equal inputs; o_stall=0.
//  3 Load-use: LW rt=8 latched, then ID has rs=8 -> o_stall=1 in that cycle; next edge ctrl buses=0, o_bubble_cnt=1; then o_stall=0.
//  4 Load to $0: LW rt=0, then ID rs=0 -> o_stall=0, no bubble.
//  5 Flush beats hazard: LW rt=8 in EX, ID rs=8, i_flush=1 -> o_stall=0; next edge ctrl buses=0, o_flush_cnt=1, o_bubble_cnt unchanged.
//  6 Freeze/saturation: i_enable=0 for 3 edges -> outputs frozen. Preload the counter to 16'hFFFF and force a hazard -> counter stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush insertion
// and saturating bubble/flush statistics counters for the debug unit.
module id_ex_hazard_reg #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_CTRL_EX = 7,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CNT     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
  input  logic [NB_DATA-1:0]    i_pc_next,
  input  logic [NB_DATA-1:0]    i_rs_data,
  input  logic [NB_DATA-1:0]    i_rt_data,
  input  logic [NB_DATA-1:0]    i_imm_ext,
  input  logic [NB_ADDR-1:0]    i_rs,
  input  logic [NB_ADDR-1:0]    i_rt,
  input  logic [NB_ADDR-1:0]    i_rd,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc_bus,
  output logic [NB_DATA-1:0]    o_pc_next,
  output logic [NB_DATA-1:0]    o_rs_data,
  output logic [NB_DATA-1:0]    o_rt_data,
  output logic [NB_DATA-1:0]    o_imm_ext,
  output logic [NB_ADDR-1:0]    o_rs,
  output logic [NB_ADDR-1:0]    o_rt,
  output logic [NB_ADDR-1:0]    o_rd,
  output logic                  o_stall,
  output logic [NB_CNT-1:0]     o_bubble_cnt,
  output logic [NB_CNT-1:0]     o_flush_cnt
);

  localparam int MEMREAD_BIT = 2;
  localparam logic [NB_CNT-1:0] CNT_MAX = '1;
  localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

  typedef enum logic [1:0] {
    ACT_RUN,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE
  } action_e;

  logic [NB_CTRL_WB-1:0] r_ctrl_wb;
  logic [NB_CTRL_M-1:0]  r_ctrl_mem;
  logic [NB_CTRL_EX-1:0] r_ctrl_exc;
  logic [NB_DATA-1:0]    r_pc_next;
  logic [NB_DATA-1:0]    r_rs_data;
  logic [NB_DATA-1:0]    r_rt_data;
  logic [NB_DATA-1:0]    r_imm_ext;
  logic [NB_ADDR-1:0]    r_rs;
  logic [NB_ADDR-1:0]    r_rt;
  logic [NB_ADDR-1:0]    r_rd;
  logic [NB_CNT-1:0]     r_bubble_cnt;
  logic [NB_CNT-1:0]     r_flush_cnt;

  logic    w_hazard;
  action_e w_action;

  // A load in EX whose destination is read by the ID instruction; $0 never hazards.
  assign w_hazard = r_ctrl_mem[MEMREAD_BIT] & (r_rt != '0) & ((r_rt == i_rs) | (r_rt == i_rt));
  assign o_stall  = w_hazard & ~i_flush;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_action = ACT_RUN;
    if (!i_enable)     w_action = ACT_HOLD;
    else if (i_flush)  w_action = ACT_FLUSH;
    else if (w_hazard) w_action = ACT_BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl_wb  <= '0;
      r_ctrl_mem <= '0;
      r_ctrl_exc <= '0;
    end else begin
      case (w_action)
        ACT_RUN: begin
          r_ctrl_wb  <= i_ctrl_wb_bus;
          r_ctrl_mem <= i_ctrl_mem_bus;
          r_ctrl_exc <= i_ctrl_exc_bus;
        end
        ACT_FLUSH, ACT_BUBBLE: begin
          r_ctrl_wb  <= '0;
          r_ctrl_mem <= '0;
          r_ctrl_exc <= '0;
        end
        default: ;
      endcase
    end
  end

  // Operands still advance during a bubble; the zeroed control makes them inert.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc_next <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm_ext <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else if (w_action != ACT_HOLD) begin
      r_pc_next <= i_pc_next;
      r_rs_data <= i_rs_data;
      r_rt_data <= i_rt_data;
      r_imm_ext <= i_imm_ext;
      r_rs      <= i_rs;
      r_rt      <= i_rt;
      r_rd      <= i_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_action == ACT_BUBBLE && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      if (w_action == ACT_FLUSH && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign o_ctrl_wb_bus  = r_ctrl_wb;
  assign o_ctrl_mem_bus = r_ctrl_mem;
  assign o_ctrl_exc_bus = r_ctrl_exc;
  assign o_pc_next      = r_pc_next;
  assign o_rs_data      = r_rs_data;
  assign o_rt_data      = r_rt_data;
  assign o_imm_ext      = r_imm_ext;
  assign o_rs           = r_rs;
  assign o_rt           = r_rt;
  assign o_rd           = r_rd;
  assign o_bubble_cnt   = r_bubble_cnt;
  assign o_flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: directed vectors push hand-computed expectations,
// a monitor pops them and compares o_stall before the edge and registered outputs after it.
module tb_id_ex_hazard_reg;

  logic        clk;
  logic        i_rst, i_enable, i_flush;
  logic [1:0]  i_wb;
  logic [2:0]  i_mem;
  logic [6:0]  i_ex;
  logic [31:0] i_pc, i_rsd, i_rtd, i_imm;
  logic [4:0]  i_rs, i_rt, i_rd;

  logic [1:0]  o_wb;
  logic [2:0]  o_mem;
  logic [6:0]  o_ex;
  logic [31:0] o_pc, o_rsd, o_rtd, o_imm;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_stall;
  logic [15:0] o_bub, o_fl;

  // Narrow-counter twin sharing the same stimulus, used to reach saturation quickly.
  logic [1:0]  s_wb;
  logic [2:0]  s_mem;
  logic [6:0]  s_ex;
  logic [31:0] s_pc, s_rsd, s_rtd, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_stall;
  logic [1:0]  s_bub, s_fl;

  id_ex_hazard_reg dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
    .i_ctrl_wb_bus(i_wb), .i_ctrl_mem_bus(i_mem), .i_ctrl_exc_bus(i_ex),
    .i_pc_next(i_pc), .i_rs_data(i_rsd), .i_rt_data(i_rtd), .i_imm_ext(i_imm),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .o_ctrl_wb_bus(o_wb), .o_ctrl_mem_bus(o_mem), .o_ctrl_exc_bus(o_ex),
    .o_pc_next(o_pc), .o_rs_data(o_rsd), .o_rt_data(o_rtd), .o_imm_ext(o_imm),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
    .o_stall(o_stall), .o_bubble_cnt(o_bub), .o_flush_cnt(o_fl)
  );

  id_ex_hazard_reg #(.NB_CNT(2)) sat_dut (
    .i_clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
    .i_ctrl_wb_bus(i_wb), .i_ctrl_mem_bus(i_mem), .i_ctrl_exc_bus(i_ex),
    .i_pc_next(i_pc), .i_rs_data(i_rsd), .i_rt_data(i_rtd), .i_imm_ext(i_imm),
    .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .o_ctrl_wb_bus(s_wb), .o_ctrl_mem_bus(s_mem), .o_ctrl_exc_bus(s_ex),
    .o_pc_next(s_pc), .o_rs_data(s_rsd), .o_rt_data(s_rtd), .o_imm_ext(s_imm),
    .o_rs(s_rs), .o_rt(s_rt), .o_rd(s_rd),
    .o_stall(s_stall), .o_bubble_cnt(s_bub), .o_flush_cnt(s_fl)
  );

  typedef struct {
    logic        rst, en, fl;
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [6:0]  ex;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d;
    logic        e_stall;
    logic [1:0]  e_wb;
    logic [2:0]  e_mem;
    logic [6:0]  e_ex;
    logic [4:0]  e_rs, e_rt, e_rd;
    logic [31:0] e_d;
    int          e_bub, e_fl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_done  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The three other data inputs are fixed functions of d that map 0 to 0.
  function automatic logic [31:0] f_pc(input logic [31:0] d);
    return {d[15:0], d[31:16]};
  endfunction
  function automatic logic [31:0] f_rt(input logic [31:0] d);
    return {d[23:0], d[31:24]};
  endfunction
  function automatic logic [31:0] f_imm(input logic [31:0] d);
    return d << 4;
  endfunction
  function automatic int sat2(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  function automatic vec_t mk(
    input int rst, en, fl, wb, mem, ex, rs, rt, rd, input logic [31:0] d,
    input int st, ewb, emem, eex, ers, ert, erd, input logic [31:0] ed,
    input int bub, flc);
    vec_t v;
    logic [31:0] t;
    t = rst;  v.rst = t[0];   t = en;   v.en  = t[0];   t = fl;  v.fl = t[0];
    t = wb;   v.wb  = t[1:0]; t = mem;  v.mem = t[2:0]; t = ex;  v.ex = t[6:0];
    t = rs;   v.rs  = t[4:0]; t = rt;   v.rt  = t[4:0]; t = rd;  v.rd = t[4:0];
    v.d = d;
    t = st;   v.e_stall = t[0];
    t = ewb;  v.e_wb = t[1:0]; t = emem; v.e_mem = t[2:0]; t = eex; v.e_ex = t[6:0];
    t = ers;  v.e_rs = t[4:0]; t = ert;  v.e_rt  = t[4:0]; t = erd; v.e_rd = t[4:0];
    v.e_d = ed; v.e_bub = bub; v.e_fl = flc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    i_rst = v.rst; i_enable = v.en; i_flush = v.fl;
    i_wb = v.wb; i_mem = v.mem; i_ex = v.ex;
    i_rs = v.rs; i_rt = v.rt; i_rd = v.rd;
    i_rsd = v.d; i_pc = f_pc(v.d); i_rtd = f_rt(v.d); i_imm = f_imm(v.d);
  endtask

  // Monitor: stall is combinational, sampled after the driver's negedge update;
  // registered outputs are sampled just after the following rising edge.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("stall", n_done, 32'(o_stall), 32'(e.e_stall));
        @(posedge clk);
        #1;
        check("ctrl_wb",   n_done, 32'(o_wb),  32'(e.e_wb));
        check("ctrl_mem",  n_done, 32'(o_mem), 32'(e.e_mem));
        check("ctrl_exc",  n_done, 32'(o_ex),  32'(e.e_ex));
        check("rs",        n_done, 32'(o_rs),  32'(e.e_rs));
        check("rt",        n_done, 32'(o_rt),  32'(e.e_rt));
        check("rd",        n_done, 32'(o_rd),  32'(e.e_rd));
        check("rs_data",   n_done, o_rsd, e.e_d);
        check("pc_next",   n_done, o_pc,  f_pc(e.e_d));
        check("rt_data",   n_done, o_rtd, f_rt(e.e_d));
        check("imm_ext",   n_done, o_imm, f_imm(e.e_d));
        check("bubble_cnt", n_done, 32'(o_bub), e.e_bub);
        check("flush_cnt",  n_done, 32'(o_fl),  e.e_fl);
        check("sat_bubble", n_done, 32'(s_bub), sat2(e.e_bub));
        check("sat_flush",  n_done, 32'(s_fl),  sat2(e.e_fl));
        n_done++;
      end
    end
  end

  initial begin
    // rst  en fl  wb mem ex     rs rt rd  d            st  ewb emem eex   ers ert erd  ed          bub fl
    vecs.push_back(mk(1, 1, 0, 3, 7, 'h7f, 8, 8, 9, 32'hDEADBEEF, 0, 0, 0, 0,     0, 0, 0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 1, 2, 3, 32'h5,        0, 2, 0, 'h41,  1, 2, 3,  32'h5,   0, 0));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 2, 8, 0, 32'h100,      0, 3, 4, 'h23,  2, 8, 0,  32'h100, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 8, 4, 10, 32'h77,      1, 0, 0, 0,     8, 4, 10, 32'h77,  1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 8, 4, 10, 32'h77,      0, 2, 0, 'h41,  8, 4, 10, 32'h77,  1, 0));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 1, 0, 0, 32'h200,      0, 3, 4, 'h23,  1, 0, 0,  32'h200, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 0, 5, 6, 32'h33,       0, 2, 0, 'h41,  0, 5, 6,  32'h33,  1, 0));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 1, 8, 0, 32'h300,      0, 3, 4, 'h23,  1, 8, 0,  32'h300, 1, 0));
    vecs.push_back(mk(0, 1, 1, 2, 0, 'h41, 8, 9, 11, 32'h44,      0, 0, 0, 0,     8, 9, 11, 32'h44,  1, 1));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 2, 7, 0, 32'h500,      0, 3, 4, 'h23,  2, 7, 0,  32'h500, 1, 1));
    vecs.push_back(mk(0, 0, 0, 2, 0, 'h41, 3, 7, 12, 32'h66,      1, 3, 4, 'h23,  2, 7, 0,  32'h500, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 1, 'h01, 7, 1, 1, 32'h99,       0, 3, 4, 'h23,  2, 7, 0,  32'h500, 1, 1));
    vecs.push_back(mk(0, 0, 0, 2, 0, 'h41, 3, 7, 12, 32'h66,      1, 3, 4, 'h23,  2, 7, 0,  32'h500, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 3, 7, 12, 32'h66,      1, 0, 0, 0,     3, 7, 12, 32'h66,  2, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 3, 7, 12, 32'h66,      0, 2, 0, 'h41,  3, 7, 12, 32'h66,  2, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 7, 3, 13, 32'h88,      0, 2, 0, 'h41,  7, 3, 13, 32'h88,  2, 1));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 0, 9, 0, 32'hA00,      0, 3, 4, 'h23,  0, 9, 0,  32'hA00, 2, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 1, 9, 14, 32'hA1,      1, 0, 0, 0,     1, 9, 14, 32'hA1,  3, 1));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 0, 10, 0, 32'hB00,     0, 3, 4, 'h23,  0, 10, 0, 32'hB00, 3, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 10, 0, 15, 32'hB1,     1, 0, 0, 0,     10, 0, 15, 32'hB1, 4, 1));
    vecs.push_back(mk(0, 1, 1, 3, 4, 'h23, 1, 2, 3, 32'hC0,       0, 0, 0, 0,     1, 2, 3,  32'hC0,  4, 2));
    vecs.push_back(mk(0, 1, 0, 3, 4, 'h23, 0, 11, 0, 32'hD00,     0, 3, 4, 'h23,  0, 11, 0, 32'hD00, 4, 2));
    vecs.push_back(mk(1, 1, 0, 2, 0, 'h41, 11, 0, 5, 32'hE0,      1, 0, 0, 0,     0, 0, 0,  32'h0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 'h41, 11, 0, 5, 32'hE0,      0, 2, 0, 'h41,  11, 0, 5, 32'hE0,  0, 0));

    // First reset edge happens before the vector stream begins.
    apply(vecs[0]);
    foreach (vecs[k]) begin
      @(negedge clk);
      apply(vecs[k]);
      sb_q.push_back(vecs[k]);
    end

    for (int k = 0; k < 10 && n_done < vecs.size(); k++) @(posedge clk);
    #2;
    check("drain", n_done, n_done, vecs.size());
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
